cart_unlock_host: RTL and testbench

CART_UNLOCK_HOST -- requirements
Module: cart_unlock_host

---
 rtl/cart_unlock_host_if.sv | 15 +
 rtl/cart_unlock_host.sv | 80 ++++++++
 tb/tb_cart_unlock_host.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/cart_unlock_host_if.sv
// cart_unlock_host_if: cartridge unlock bus plus host status, master = host side.
interface cart_unlock_host_if;
    logic        START;
    logic [7:0]  ADDR;
    logic        CEn;
    logic        SSn;
    logic        SI;
    logic        BUSY;
    logic        DONE;
    logic        ERR;
    logic [15:0] WORD;
    logic        UNLOCKED;
    modport master (input START, SI, output ADDR, CEn, SSn, BUSY, DONE, ERR, WORD, UNLOCKED);
    modport slave  (output START, SI, input ADDR, CEn, SSn, BUSY, DONE, ERR, WORD, UNLOCKED);
endinterface

// File: rtl/cart_unlock_host.sv
// cart_unlock_host: issues the 5A/A5 unlock address pair, then receives a framed
// 16-bit LSB-first word on SI and latches the sticky UNLOCKED flag on a match.
module cart_unlock_host #(
    parameter int unsigned   TIMEOUT     = 32,
    parameter logic [15:0]   EXPECT_WORD = 16'h28A0
) (
    input  logic               CLK,
    input  logic               RSTn,
    cart_unlock_host_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_ACK, S_NAK, S_WAIT, S_DATA, S_STOP, S_DONE, S_FAIL} state_t;
    state_t      state_q, state_d;
    logic [3:0]  bcnt_q, bcnt_d;
    logic [7:0]  tcnt_q, tcnt_d;
    logic [15:0] word_q, word_d;
    logic        unl_q, unl_d;
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) state_q <= S_IDLE;
        else       state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_FAIL: state_d = bus.START ? S_ACK : state_q;
            S_ACK:  state_d = S_NAK;
            S_NAK:  state_d = S_WAIT;
            S_WAIT: state_d = !bus.SI ? S_DATA : (tcnt_q == 8'(TIMEOUT - 1)) ? S_FAIL : S_WAIT;
            S_DATA: state_d = (bcnt_q == 4'd15) ? S_STOP : S_DATA;
            S_STOP: state_d = bus.SI ? S_FAIL : S_DONE;
            default: state_d = S_IDLE;
        endcase
    end
    always_comb begin
        bus.ADDR     = (state_q == S_ACK) ? 8'h5A : (state_q == S_NAK) ? 8'hA5 : 8'hFF;
        bus.CEn      = !(state_q inside {S_ACK, S_NAK});
        bus.SSn      = 1'b1;
        bus.BUSY     = state_q inside {S_ACK, S_NAK, S_WAIT, S_DATA, S_STOP};
        bus.DONE     = state_q == S_DONE;
        bus.ERR      = state_q == S_FAIL;
        bus.WORD     = word_q;
        bus.UNLOCKED = unl_q;
    end
    // Datapath: counters and the received word, cleared on each accepted START.
    always_comb begin
        bcnt_d = bcnt_q;
        tcnt_d = tcnt_q;
        word_d = word_q;
        unl_d  = unl_q;
        case (state_q)
            S_IDLE, S_DONE, S_FAIL: begin
                bcnt_d = bus.START ? 4'd0 : bcnt_q;
                tcnt_d = bus.START ? 8'd0 : tcnt_q;
                word_d = bus.START ? 16'd0 : word_q;
            end
            S_WAIT: begin
                bcnt_d = 4'd0;
                tcnt_d = bus.SI ? tcnt_q + 8'd1 : tcnt_q;
            end
            S_DATA: begin
                word_d = {bus.SI, word_q[15:1]};
                bcnt_d = bcnt_q + 4'd1;
            end
            S_STOP: unl_d = unl_q | (!bus.SI && word_q == EXPECT_WORD);
            default: ;
        endcase
    end
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            bcnt_q <= '0;
            tcnt_q <= '0;
            word_q <= '0;
            unl_q  <= 1'b0;
        end else begin
            bcnt_q <= bcnt_d;
            tcnt_q <= tcnt_d;
            word_q <= word_d;
            unl_q  <= unl_d;
        end
    end
endmodule

// File: tb/tb_cart_unlock_host.sv
// tb_cart_unlock_host: randomized cartridge responses checked every cycle against a
// transaction-level model that derives the whole output timeline from the SI plan.
module tb_cart_unlock_host;
    localparam int          TO  = 32;
    localparam logic [15:0] EXP = 16'h28A0;
    logic clk = 1'b0, rstn = 1'b1, chk = 1'b0;
    int total = 0, bad = 0;
    cart_unlock_host_if bus();
    cart_unlock_host #(.TIMEOUT(TO), .EXPECT_WORD(EXP)) dut (.CLK(clk), .RSTn(rstn), .bus(bus));
    always #5 clk = ~clk;

    logic [7:0]  m_addr;
    logic        m_cen, m_busy, m_done, m_err, m_unl;
    logic [15:0] m_word;
    logic        si_plan [0:63];
    int          s_edge, end_edge, first_end;
    logic        ok_end, d0, u0;
    logic [15:0] fin_word;
    logic [7:0]  a0, a1;

    function automatic void cmp(string nm, logic [15:0] act, logic [15:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp_v, $time);
        end
    endfunction

    function automatic void model_reset();
        m_addr = 8'hFF; m_cen = 1'b1; m_busy = 1'b0; m_done = 1'b0;
        m_err = 1'b0; m_word = 16'h0; m_unl = 1'b0;
    endfunction

    // Cartridge behaviour: random don't-care bits in ACK/NAK, start bit after d idle edges.
    function automatic void make_plan(int d, logic [15:0] w, logic stopb);
        for (int k = 0; k < 64; k++) si_plan[k] = (k < 3) ? 1'($urandom) : 1'b1;
        if (d < TO) begin
            si_plan[3 + d] = 1'b0;
            for (int i = 0; i < 16; i++) si_plan[4 + d + i] = w[i];
            si_plan[20 + d] = stopb;
        end
    endfunction

    // Outcome of a transaction from the SI plan alone; edge 0 is the START edge.
    function automatic void plan_outcome();
        s_edge = -1;
        for (int k = 3; k < 3 + TO; k++) if (s_edge < 0 && !si_plan[k]) s_edge = k;
        fin_word = 16'h0;
        if (s_edge < 0) begin
            end_edge = 2 + TO;
            ok_end   = 1'b0;
        end else begin
            for (int i = 0; i < 16; i++) fin_word[i] = si_plan[s_edge + 1 + i];
            end_edge = s_edge + 17;
            ok_end   = !si_plan[end_edge];
        end
    endfunction

    function automatic void model_edge(int n);
        logic [31:0] t;
        int j;
        m_busy = n < end_edge;
        m_addr = (n == 0) ? 8'h5A : (n == 1) ? 8'hA5 : 8'hFF;
        m_cen  = n > 1;
        m_done = n >= end_edge && ok_end;
        m_err  = n >= end_edge && !ok_end;
        j = (s_edge < 0) ? 0 : n - s_edge;
        j = (j < 0) ? 0 : (j > 16) ? 16 : j;
        t = ({16'h0, fin_word} & ((32'd1 << j) - 32'd1)) << (16 - j);
        m_word = t[15:0];
        if (n == end_edge && ok_end && fin_word == EXP) m_unl = 1'b1;
    endfunction

    always @(negedge clk) if (chk) begin
        cmp("addr", 16'(bus.ADDR), 16'(m_addr));
        cmp("cen", 16'(bus.CEn), 16'(m_cen));
        cmp("ssn", 16'(bus.SSn), 16'd1);
        cmp("busy", 16'(bus.BUSY), 16'(m_busy));
        cmp("done", 16'(bus.DONE), 16'(m_done));
        cmp("err", 16'(bus.ERR), 16'(m_err));
        cmp("word", bus.WORD, m_word);
        cmp("unlocked", 16'(bus.UNLOCKED), 16'(m_unl));
    end

    task automatic check_reset_vals(string tag);
        cmp({tag, "_addr"}, 16'(bus.ADDR), 16'hFF);
        cmp({tag, "_cen"}, 16'(bus.CEn), 16'd1);
        cmp({tag, "_busy"}, 16'(bus.BUSY), 16'd0);
        cmp({tag, "_done"}, 16'(bus.DONE), 16'd0);
        cmp({tag, "_err"}, 16'(bus.ERR), 16'd0);
        cmp({tag, "_word"}, bus.WORD, 16'd0);
        cmp({tag, "_unl"}, 16'(bus.UNLOCKED), 16'd0);
    endtask

    task automatic do_reset();
        #2 rstn = 1'b0;
        #1 check_reset_vals("rst_now");
        model_reset();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        bus.START = 1'b0;
        bus.SI = 1'b1;
    endtask

    task automatic txn(input int restart_at, input int abort_at);
        plan_outcome();
        first_end = -1;
        for (int n = 0; n <= end_edge + 2; n++) begin
            @(negedge clk);
            bus.START = (n == 0) || (n == restart_at);
            bus.SI = si_plan[n];
            @(posedge clk);
            #1 model_edge(n);
            if (n == 0) begin a0 = bus.ADDR; d0 = bus.DONE; u0 = bus.UNLOCKED; end
            if (n == 1) a1 = bus.ADDR;
            if (first_end < 0 && (bus.DONE || bus.ERR)) first_end = n;
            if (n == abort_at) begin
                do_reset();
                return;
            end
        end
        @(negedge clk);
        bus.START = 1'b0;
        bus.SI = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d, ra, ab;
        logic [15:0] w;
        bus.START = 1'b0;
        bus.SI = 1'b1;
        model_reset();
        #1 rstn = 1'b0;
        #1 check_reset_vals("init");
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        chk = 1'b1;
        // SI stuck high: ERR exactly TIMEOUT edges after WAIT entry
        make_plan(TO, 16'h0, 1'b0);
        txn(-1, -1);
        cmp("to_first_end", 16'(first_end), 16'd34);
        cmp("to_err", 16'(bus.ERR), 16'd1);
        cmp("to_unl", 16'(bus.UNLOCKED), 16'd0);
        cmp("to_word", bus.WORD, 16'h0);
        make_plan(0, 16'h1234, 1'b0);
        txn(-1, -1);
        cmp("w1234_done", 16'(bus.DONE), 16'd1);
        cmp("w1234_word", bus.WORD, 16'h1234);
        cmp("w1234_unl", 16'(bus.UNLOCKED), 16'd0);
        make_plan(0, EXP, 1'b1);
        txn(-1, -1);
        cmp("badstop_err", 16'(bus.ERR), 16'd1);
        cmp("badstop_done", 16'(bus.DONE), 16'd0);
        cmp("badstop_unl", 16'(bus.UNLOCKED), 16'd0);
        cmp("badstop_word", bus.WORD, 16'h28A0);
        make_plan(0, EXP, 1'b0);
        txn(-1, -1);
        cmp("good_first_end", 16'(first_end), 16'd20);
        cmp("good_a0", 16'(a0), 16'h5A);
        cmp("good_a1", 16'(a1), 16'hA5);
        cmp("good_done", 16'(bus.DONE), 16'd1);
        cmp("good_word", bus.WORD, 16'h28A0);
        cmp("good_unl", 16'(bus.UNLOCKED), 16'd1);
        // reset at DATA bit 7 (edge 11), then a clean rerun
        make_plan(0, EXP, 1'b0);
        txn(-1, 11);
        make_plan(0, EXP, 1'b0);
        txn(-1, -1);
        cmp("rerun_done", 16'(bus.DONE), 16'd1);
        cmp("rerun_unl", 16'(bus.UNLOCKED), 16'd1);
        // START during WAIT ignored; start bit at edge 8 gives DONE at edge 25
        make_plan(5, 16'h0F0F, 1'b0);
        txn(4, -1);
        cmp("wait_start_end", 16'(first_end), 16'd25);
        cmp("wait_start_done", 16'(bus.DONE), 16'd1);
        make_plan(0, 16'h1111, 1'b0);
        txn(-1, -1);
        cmp("restart_done_drop", 16'(d0), 16'd0);
        cmp("restart_unl_kept", 16'(u0), 16'd1);
        for (int r = 0; r < 40; r++) begin
            d = $urandom_range(0, TO + 2);
            w = ($urandom_range(0, 2) == 0) ? EXP : 16'($urandom);
            make_plan(d, w, ($urandom_range(0, 3) == 0));
            plan_outcome();
            ra = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, end_edge - 1)) : -1;
            ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, end_edge)) : -1;
            txn(ra, ab);
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                bus.SI = 1'($urandom);
            end
        end
        @(negedge clk);
        chk = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
